// File: rtl/riscv_pkg.sv
// Shared RV32 load/store definitions: funct3 width codes, LSU state
// encoding, default memory timeout and small width-decoding helpers.
package riscv_pkg;

  // RV32I load/store width codes (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Cycles the LSU waits for mem_ready before aborting an access
  localparam int unsigned LSU_MEM_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Access size; the unused codes 011/110/111 behave as a full word
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Force the low address bits onto the natural boundary of the access size
  function automatic logic [1:0] align_low(input lsu_size_e sz, input logic [1:0] a);
    case (sz)
      SZ_B:    return a;
      SZ_H:    return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// lsu_align: combinational byte-lane logic for the LSU. Produces the store
// byte mask, the lane-replicated store data and the extended load data.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  lsu_size_e   size;
  logic        is_unsigned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension for the current access size
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    size        = f3_size(funct3);
    is_unsigned = f3_unsigned(funct3);
    byte_sel    = rdata[{addr_lo, 3'b000} +: 8];
    half_sel    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    wmask       = 4'b1111;
    wdata_rep   = wdata;
    rdata_ext   = rdata;
    case (size)
      SZ_B: begin
        wmask     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        wmask     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: RV32I load/store unit. IDLE -> ACCESS -> WAIT -> RESP handshake
// towards a word-addressed memory with a bounded wait for mem_ready.
// Optional feature macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses go
// straight to an error response; otherwise their low address bits are
// forced to alignment and the access proceeds.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = LSU_MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic        mem_rstrb_q, mem_rstrb_d;

  logic [1:0]  req_addr_lo;
  logic        misaligned;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  // Misalignment handling for the incoming request
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    req_addr_lo = req_addr[1:0];
    case (f3_size(req_funct3))
      SZ_H:    misaligned = req_addr[0];
      SZ_W:    misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
`else
    req_addr_lo = align_low(f3_size(req_funct3), req_addr[1:0]);
    misaligned  = 1'b0;
`endif
  end

  // Lane logic sees the live request in IDLE and the latched one afterwards
  always_comb begin
    al_funct3  = (state_q == ST_IDLE) ? req_funct3  : funct3_q;
    al_addr_lo = (state_q == ST_IDLE) ? req_addr_lo : addr_lo_q;
  end

  lsu_align u_align (
    .funct3    (al_funct3),
    .addr_lo   (al_addr_lo),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .wmask     (al_wmask),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  // Next state and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    mem_rstrb_d = mem_rstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          funct3_d    = req_funct3;
          addr_lo_d   = req_addr_lo;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          req_ready_d = 1'b0;
          if (misaligned) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = ST_ACCESS;
            mem_wdata_d = al_wdata;
            mem_wmask_d = req_we ? al_wmask : 4'b0000;
            mem_rstrb_d = ~req_we;
          end
        end
      end
      ST_ACCESS: begin
        state_d     = ST_WAIT;
        cnt_d       = '0;
        mem_wmask_d = 4'b0000;
        mem_rstrb_d = 1'b0;
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? '0 : al_rdata;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      mem_rstrb_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      mem_rstrb_q <= mem_rstrb_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_rstrb = mem_rstrb_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu. Expected responses are queued when a
// request is driven and compared when rsp_valid appears. Expectations for
// misaligned accesses follow LSU_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module tb_riscv_lsu;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  riscv_lsu #(.MEM_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rstrb  (mem_rstrb),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access. delay = WAIT cycles with mem_ready low before it goes high
  // (-1: never). exp_lat counts cycles after the accept edge up to and
  // including the response cycle (1 = direct error response).
  task automatic do_access(
    input string       name,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] rword,
    input int          delay,
    input logic [31:0] exp_addr,
    input logic [3:0]  exp_mask,
    input logic [31:0] exp_wdata,
    input logic [31:0] exp_rdata,
    input logic        exp_err,
    input int          exp_lat
  );
    exp_t e;
    exp_t g;
    int   cyc;
    int   n;
    bit   done;
    bit   leak;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, ":req_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    if (exp_lat != 1) begin
      check({name, ":mem_addr"}, mem_addr, exp_addr);
      check({name, ":wmask"}, 32'(mem_wmask), 32'(exp_mask));
      check({name, ":rstrb"}, 32'(mem_rstrb), 32'(!we));
      if (we) check({name, ":wdata"}, mem_wdata, exp_wdata);
    end else begin
      check({name, ":wmask"}, 32'(mem_wmask), 32'd0);
      check({name, ":rstrb"}, 32'(mem_rstrb), 32'd0);
    end
    done = 1'b0;
    leak = 1'b0;
    while (!done && cyc < TO + 10) begin
      if (rsp_valid) begin
        done      = 1'b1;
        mem_ready = 1'b0;
        if (sb.size() == 0) begin
          check({name, ":unexpected_rsp"}, 32'd1, 32'd0);
        end else begin
          g = sb.pop_front();
          check({name, ":latency"}, 32'(cyc), 32'(g.lat));
          check({name, ":rdata"}, rsp_rdata, g.rdata);
          check({name, ":err"}, 32'(rsp_err), 32'(g.err));
        end
      end else begin
        if (cyc >= 2 && (mem_wmask != 4'b0000 || mem_rstrb)) leak = 1'b1;
        if (cyc == 1) begin
          // ACCESS cycle: a stray ready with a wrong word must be ignored
          mem_ready = 1'b1;
          mem_rdata = ~rword;
        end else if (delay >= 0 && cyc - 1 == delay + 1) begin
          mem_ready = 1'b1;
          mem_rdata = rword;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = ~rword;
        end
        @(negedge clk);
        cyc++;
      end
    end
    mem_ready = 1'b0;
    check({name, ":rsp_seen"}, 32'(done), 32'd1);
    check({name, ":strobe_leak"}, 32'(leak), 32'd0);
    @(negedge clk);
    check({name, ":rsp_pulse"}, 32'(rsp_valid), 32'd0);
    check({name, ":back_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst:req_ready", 32'(req_ready), 32'd1);
    check("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst:rsp_err", 32'(rsp_err), 32'd0);
    check("rst:rsp_rdata", rsp_rdata, 32'd0);
    check("rst:mem_addr", mem_addr, 32'd0);
    check("rst:mem_wdata", mem_wdata, 32'd0);
    check("rst:mem_wmask", 32'(mem_wmask), 32'd0);
    check("rst:mem_rstrb", 32'(mem_rstrb), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    //         name        we    f3      addr          wdata         rword         dly   exp_addr      mask     exp_wdata     exp_rdata     err   lat
    do_access("st_b",     1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        0,    32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 32'h0,        1'b0, 3);
    do_access("ld_b",     1'b0, 3'b000, 32'h0000_0102, 32'h0,        32'h12F0_5634, 0,    32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FFF0, 1'b0, 3);
    do_access("ld_bu",    1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h12F0_5634, 0,    32'h0000_0100, 4'b0000, 32'h0,        32'h0000_00F0, 1'b0, 3);
    do_access("ld_hu",    1'b0, 3'b101, 32'h0000_0202, 32'h0,        32'h8001_ABCD, 5,    32'h0000_0200, 4'b0000, 32'h0,        32'h0000_8001, 1'b0, 8);
    do_access("ld_h",     1'b0, 3'b001, 32'h0000_0200, 32'h0,        32'h1234_8765, 1,    32'h0000_0200, 4'b0000, 32'h0,        32'hFFFF_8765, 1'b0, 4);
    do_access("ld_w",     1'b0, 3'b010, 32'h0000_0300, 32'h0,        32'hDEAD_BEEF, 2,    32'h0000_0300, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0, 5);
    do_access("st_h",     1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h0,        0,    32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0, 3);
    do_access("st_w",     1'b1, 3'b010, 32'h0000_0104, 32'h1122_3344, 32'h0,        3,    32'h0000_0104, 4'b1111, 32'h1122_3344, 32'h0,        1'b0, 6);
    do_access("ld_ill",   1'b0, 3'b011, 32'h0000_0010, 32'h0,        32'hCAFE_F00D, 0,    32'h0000_0010, 4'b0000, 32'h0,        32'hCAFE_F00D, 1'b0, 3);
    do_access("timeout",  1'b0, 3'b010, 32'h0000_0040, 32'h0,        32'h5555_AAAA, -1,   32'h0000_0040, 4'b0000, 32'h0,        32'h0,        1'b1, TO + 2);
    do_access("to_race",  1'b0, 3'b010, 32'h0000_0044, 32'h0,        32'h0BAD_CAFE, TO-1, 32'h0000_0044, 4'b0000, 32'h0,        32'h0BAD_CAFE, 1'b0, TO + 2);
`ifdef LSU_MISALIGN_TRAP_EN
    do_access("mis_st_w", 1'b1, 3'b010, 32'h0000_0101, 32'h5566_7788, 32'h0,        0,    32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1);
    do_access("mis_ld_h", 1'b0, 3'b001, 32'h0000_0203, 32'h0,        32'hA5C3_1111, 0,    32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1);
`else
    do_access("mis_st_w", 1'b1, 3'b010, 32'h0000_0101, 32'h5566_7788, 32'h0,        0,    32'h0000_0100, 4'b1111, 32'h5566_7788, 32'h0,        1'b0, 3);
    do_access("mis_ld_h", 1'b0, 3'b001, 32'h0000_0203, 32'h0,        32'hA5C3_1111, 0,    32'h0000_0200, 4'b0000, 32'h0,        32'hFFFF_A5C3, 1'b0, 3);
`endif

    // Reset while in WAIT: back to IDLE, no response, late mem_ready ignored
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0500;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid:req_ready", 32'(req_ready), 32'd1);
    check("rst_mid:rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid:rstrb", 32'(mem_rstrb), 32'd0);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h7777_7777;
    seen      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    mem_ready = 1'b0;
    check("rst_mid:late_ready", 32'(seen), 32'd0);
    check("rst_mid:idle", 32'(req_ready), 32'd1);

    // A normal access still works after the aborted one
    do_access("post_rst", 1'b0, 3'b000, 32'h0000_0601, 32'h0, 32'h0000_7F00, 0, 32'h0000_0600, 4'b0000, 32'h0, 32'h0000_007F, 1'b0, 3);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum number of cycles spent in WAIT before an access is aborted.
REQ-002 clk  in  1  core clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  core presents a load/store request.
REQ-005 req_ready  out  1  LSU can accept a request; high only in IDLE.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  in  32  byte address (rs1 + imm).
REQ-009 req_wdata  in  32  store data (rs2), LSB-justified.
REQ-010 rsp_valid  out  1  one-cycle pulse marking a completed access.
REQ-011 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-012 rsp_err  out  1  qualifies rsp_valid: misaligned access or timeout.
REQ-013 mem_addr  out  32  word address: req_addr with bits [1:0] cleared.
REQ-014 mem_wdata  out  32  store data replicated into its byte lanes.
REQ-015 mem_wmask  out  4  byte write enables; non-zero only in the ACCESS cycle of a store.
REQ-016 mem_rstrb  out  1  read strobe; high only in the ACCESS cycle of a load.
REQ-017 mem_rdata  in  32  memory read word, valid while mem_ready is high.
REQ-018 mem_ready  in  1  memory completion indication.

Function
REQ-019 The FSM SHALL have four states: IDLE, ACCESS, WAIT and RESP.
REQ-020 IDLE transitions to ACCESS when req_valid is high, and latches the request fields on that edge.
REQ-021 ACCESS lasts exactly one cycle, then moves to WAIT.
REQ-022 WAIT transitions to RESP on the first cycle mem_ready is high, and latches mem_rdata on that edge.
REQ-023 RESP lasts exactly one cycle with rsp_valid high, then returns to IDLE.
REQ-024 With mem_ready high in the first WAIT cycle, rsp_valid SHALL rise three cycles after the accept edge.
REQ-025 mem_ready is ignored outside WAIT.
REQ-026 The store mask SHALL be: B = 0001 << a[1:0]; H = 0011 << (a[1] * 2); W = 1111.
REQ-027 Store lane replication SHALL be: B = {4{d[7:0]}}; H = {2{d[15:0]}}; W = d.
REQ-028 Load extraction SHALL select the byte or halfword lane by a[1:0] or a[1].
REQ-029 Load extension SHALL sign-extend for B and H, and zero-extend for BU and HU.
REQ-030 An illegal funct3 (011, 110, 111) SHALL be treated as W.
REQ-031 The WAIT counter SHALL be 8 bits wide and clear on entry to WAIT.
REQ-032 If MEM_TIMEOUT cycles elapse in WAIT without mem_ready, the FSM SHALL enter RESP with rsp_err = 1 and rsp_rdata = 0.
REQ-033 A req_valid pulse arriving outside IDLE SHALL be ignored; the core must hold req_valid until req_ready is high.
REQ-034 mem_ready and the timeout occurring in the same cycle SHALL resolve as success (mem_ready wins).

Reset
REQ-035 While rst_n is low at a clock edge, the state SHALL become IDLE and the counter SHALL clear.
REQ-036 Reset values SHALL be: req_ready = 1; rsp_valid, rsp_err, mem_rstrb, mem_wmask, mem_wdata, mem_addr, rsp_rdata = 0.
REQ-037 Reset asserted mid-access SHALL abort the access with no rsp_valid; a late mem_ready is then ignored.

Configuration
REQ-038 The macro LSU_MISALIGN_TRAP_EN selects misalignment handling.
REQ-039 With LSU_MISALIGN_TRAP_EN defined, an H access with a[0] = 1, or a W access with a[1:0] != 0, SHALL skip ACCESS and WAIT.
REQ-040 In that case it SHALL go IDLE to RESP with rsp_err = 1, no strobe, and mem_wmask = 0.
REQ-041 Without LSU_MISALIGN_TRAP_EN, the low address bits SHALL be forced to alignment (H: a[0] = 0; W: a[1:0] = 0), the access SHALL proceed normally, and rsp_err SHALL be set only by timeout.

Structure
REQ-042 The shared package riscv_pkg SHALL hold the funct3 width constants, the LSU state encoding and the default MEM_TIMEOUT.
REQ-043 A combinational sub-module, lsu_align, SHALL compute the mask, the replicated store data and the extended load data.

Verification
REQ-044 Store B: addr 0x103, data 0x000000A5 -> mem_addr 0x100, wmask 1000, wdata 0xA5A5A5A5, rsp_valid 3 cycles after accept (mem_ready immediate).
REQ-045 Load B: addr 0x102, mem_rdata 0x12F05634 -> rsp_rdata 0xFFFFFFF0; the same access as BU -> 0x000000F0.
REQ-046 Load HU: addr 0x202, mem_rdata 0x8001ABCD, mem_ready after 5 WAIT cycles -> rsp_rdata 0x00008001; rsp_valid exactly one cycle.
REQ-047 Timeout: mem_ready held low -> rsp_valid with rsp_err 1 and rdata 0 after MEM_TIMEOUT WAIT cycles; mem_ready in the same cycle as the timeout -> rsp_err 0.
REQ-048 Misaligned W store at 0x101: with the macro -> rsp_err 1, wmask never non-zero; without it -> mem_addr 0x100, wmask 1111, rsp_err 0.
REQ-049 rst_n low during WAIT -> IDLE next cycle, no rsp_valid, and a subsequent mem_ready is ignored.
